// File: rtl/apb_regbank_slave_if.sv
// APB4 completer bus bundle for apb_regbank_slave.
// master drives the request side, slave returns data/ready/error.
interface apb_regbank_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   paddr;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [DATA_W-1:0]   pwdata;
    logic [DATA_W/8-1:0] pstrb;
    logic [DATA_W-1:0]   prdata;
    logic                pready;
    logic                pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_regbank_slave.sv
// APB4 register bank completer: NUM_REGS R/W registers with byte strobes,
// fixed wait states and a one-cycle write pulse per register.
// Optional feature macro: APB_REGBANK_SLVERR_EN (error response on bad
// address or empty-strobe write). Default build leaves pslverr at 0.

// One register of the bank: byte-lane write enable, reset value, write pulse.
module apb_regbank_reg #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [DATA_W/8-1:0] strb,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   q,
    output logic                stb
);
    // Storage update per byte lane; stb is the registered commit pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= RESET_VAL;
            stb <= 1'b0;
        end else begin
            stb <= we;
            if (we) begin
                for (int b = 0; b < DATA_W/8; b++) begin
                    if (strb[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end
endmodule

module apb_regbank_slave #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_REGS    = 8,
    parameter int                WAIT_STATES = 0,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    apb_regbank_slave_if.slave           apb,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic [NUM_REGS-1:0]          wr_stb_o
);
    localparam int NB    = DATA_W / 8;
    localparam int OFS   = $clog2(NB);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << OFS) - 1);

    // SETUP is never stored: it is the IDLE cycle in which psel=1/penable=0
    // is seen. Registering it would add a cycle to every transfer, so the
    // register moves IDLE->ACCESS and SETUP exists only as a decoded phase.
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             addr_ok;
        logic             wr;
    } req_t;

    state_t state_q, state_d, phase;
    logic [3:0] cnt_q, cnt_d;
    logic       pready, err, commit;
    req_t       req;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;

    // Address decode: aligned and inside the bank.
    always_comb begin
        req.idx     = apb.paddr[OFS +: IDX_W];
        req.addr_ok = ((apb.paddr & LOW_MASK) == '0) &&
                      ((apb.paddr >> OFS) < ADDR_W'(NUM_REGS));
        req.wr      = apb.pwrite;
    end

    // State and wait counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter and ready. penable=1 in IDLE is ignored; psel
    // dropping in ACCESS aborts back to IDLE, so a new SETUP can follow.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase   = state_q;
        pready  = 1'b0;
        case (state_q)
            IDLE: begin
                if (apb.psel && !apb.penable) begin
                    phase   = SETUP;
                    state_d = ACCESS;
                    cnt_d   = 4'(WAIT_STATES);
                end
            end
            ACCESS: begin
                pready = (cnt_q == '0);
                if (!apb.psel || pready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef APB_REGBANK_SLVERR_EN
    assign err         = !req.addr_ok || (req.wr && (apb.pstrb == '0));
    assign apb.pslverr = pready && err;
`else
    assign err         = !req.addr_ok;
    assign apb.pslverr = 1'b0;
`endif

    // Only a completed (psel still high), error-free, in-range write commits.
    assign commit     = pready && apb.psel && req.wr && !err;
    assign apb.pready = pready;
    assign apb.prdata = (pready && !req.wr && !err) ? regs_q[req.idx] : '0;
    assign regs_o     = regs_q;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        apb_regbank_reg #(
            .DATA_W    (DATA_W),
            .RESET_VAL (RESET_VAL)
        ) u_reg (
            .clk   (clk),
            .rst   (rst),
            .we    (commit && (req.idx == IDX_W'(k))),
            .strb  (apb.pstrb),
            .wdata (apb.pwdata),
            .q     (regs_q[k]),
            .stb   (wr_stb_o[k])
        );
    end
endmodule

// File: tb/tb_apb_regbank_slave.sv
// Directed bench for apb_regbank_slave: one bank with no wait states and
// zero reset value, one with 3 wait states and a nonzero reset value.
module tb_apb_regbank_slave;
    localparam logic [31:0] RV = 32'h5A5A_0001;
`ifdef APB_REGBANK_SLVERR_EN
    localparam logic SE = 1'b1;
`else
    localparam logic SE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0]  paddr_v   [2];
    logic         psel_v    [2];
    logic         penable_v [2];
    logic         pwrite_v  [2];
    logic [31:0]  pwdata_v  [2];
    logic [3:0]   pstrb_v   [2];
    logic [31:0]  prdata_w  [2];
    logic         pready_w  [2];
    logic         pslverr_w [2];
    logic [255:0] regs_w    [2];
    logic [7:0]   stb_w     [2];

    apb_regbank_slave_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    apb_regbank_slave_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

    assign bus0.paddr = paddr_v[0];   assign bus3.paddr = paddr_v[1];
    assign bus0.psel = psel_v[0];     assign bus3.psel = psel_v[1];
    assign bus0.penable = penable_v[0]; assign bus3.penable = penable_v[1];
    assign bus0.pwrite = pwrite_v[0]; assign bus3.pwrite = pwrite_v[1];
    assign bus0.pwdata = pwdata_v[0]; assign bus3.pwdata = pwdata_v[1];
    assign bus0.pstrb = pstrb_v[0];   assign bus3.pstrb = pstrb_v[1];
    assign prdata_w[0] = bus0.prdata;   assign prdata_w[1] = bus3.prdata;
    assign pready_w[0] = bus0.pready;   assign pready_w[1] = bus3.pready;
    assign pslverr_w[0] = bus0.pslverr; assign pslverr_w[1] = bus3.pslverr;

    apb_regbank_slave #(
        .ADDR_W(32), .DATA_W(32), .NUM_REGS(8), .WAIT_STATES(0), .RESET_VAL(32'h0)
    ) dut0 (
        .clk(clk), .rst(rst), .apb(bus0), .regs_o(regs_w[0]), .wr_stb_o(stb_w[0])
    );

    apb_regbank_slave #(
        .ADDR_W(32), .DATA_W(32), .NUM_REGS(8), .WAIT_STATES(3), .RESET_VAL(RV)
    ) dut3 (
        .clk(clk), .rst(rst), .apb(bus3), .regs_o(regs_w[1]), .wr_stb_o(stb_w[1])
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          d;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_waits;
        logic [7:0]  exp_stb;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(int d, logic wr, logic [31:0] a, logic [31:0] dat,
                                logic [3:0] s, logic [31:0] rd, logic e, int w,
                                logic [7:0] stb);
        vec_t v;
        v.d = d; v.wr = wr; v.addr = a; v.data = dat; v.strb = s;
        v.exp_rd = rd; v.exp_err = e; v.exp_waits = w; v.exp_stb = stb;
        return v;
    endfunction

    // Drives SETUP (sampled at the next posedge), then ACCESS until pready.
    // Returns one posedge after the pready cycle with the bus released.
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        output logic [31:0] rd, output logic err,
                        output int waits, output logic ok);
        paddr_v[d] = addr; pwrite_v[d] = wr; pwdata_v[d] = data; pstrb_v[d] = strb;
        psel_v[d] = 1'b1; penable_v[d] = 1'b0;
        @(posedge clk); #1;
        penable_v[d] = 1'b1;
        waits = 0; ok = 1'b0; rd = '0; err = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pready_w[d]) begin
                rd = prdata_w[d]; err = pslverr_w[d]; ok = 1'b1;
                break;
            end
            waits++;
        end
        @(posedge clk); #1;
        psel_v[d] = 1'b0; penable_v[d] = 1'b0;
    endtask

    logic [31:0] rd;
    logic        err, ok;
    int          waits;

    initial begin
        for (int d = 0; d < 2; d++) begin
            paddr_v[d] = '0; psel_v[d] = 1'b0; penable_v[d] = 1'b0;
            pwrite_v[d] = 1'b0; pwdata_v[d] = '0; pstrb_v[d] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst pready0", pready_w[0], 0);
        chk("rst pready3", pready_w[1], 0);
        chk("rst pslverr3", pslverr_w[1], 0);
        chk("rst prdata3", prdata_w[1], 0);
        chk("rst stb0", stb_w[0], 0);
        chk("rst stb3", stb_w[1], 0);
        chk("rst regs0", regs_w[0], 256'h0);
        chk("rst regs3", regs_w[1], {8{RV}});

        // Vector table
        for (int r = 0; r < 8; r++)
            vq.push_back(mk(0, 0, 32'(r*4), 0, 4'hF, 32'h0, 0, 0, 8'h00));
        vq.push_back(mk(0, 1, 32'h1C, 32'h00C0FFEE, 4'hF, 0, 0, 0, 8'h80));
        vq.push_back(mk(0, 0, 32'h1C, 0, 4'h0, 32'h00C0FFEE, 0, 0, 8'h00));
        vq.push_back(mk(1, 1, 32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 3, 8'h04));
        vq.push_back(mk(1, 1, 32'h04, 32'hAABBCCDD, 4'hF, 0, 0, 3, 8'h02));
        vq.push_back(mk(1, 1, 32'h04, 32'h11223344, 4'h5, 0, 0, 3, 8'h02));
        vq.push_back(mk(1, 0, 32'h04, 0, 4'h0, 32'hAA22CC44, 0, 3, 8'h00));
        vq.push_back(mk(1, 0, 32'h08, 0, 4'hF, 32'hDEADBEEF, 0, 3, 8'h00));
        vq.push_back(mk(1, 0, 32'h0C, 0, 4'hF, RV, 0, 3, 8'h00));
        vq.push_back(mk(1, 1, 32'h20, 32'h12345678, 4'hF, 0, SE, 3, 8'h00));
        vq.push_back(mk(1, 1, 32'h06, 32'h12345678, 4'hF, 0, SE, 3, 8'h00));
        vq.push_back(mk(1, 0, 32'h20, 0, 4'hF, 32'h0, SE, 3, 8'h00));
        vq.push_back(mk(1, 1, 32'h00, 32'hFFFFFFFF, 4'h0, 0, SE, 3, SE ? 8'h00 : 8'h01));
        vq.push_back(mk(1, 0, 32'h00, 0, 4'hF, RV, 0, 3, 8'h00));

        foreach (vq[i]) begin
            xfer(vq[i].d, vq[i].wr, vq[i].addr, vq[i].data, vq[i].strb, rd, err, waits, ok);
            chk($sformatf("v%0d done", i), ok, 1);
            chk($sformatf("v%0d waits", i), waits, vq[i].exp_waits);
            chk($sformatf("v%0d pslverr", i), err, vq[i].exp_err);
            if (!vq[i].wr) chk($sformatf("v%0d prdata", i), rd, vq[i].exp_rd);
            @(negedge clk);
            chk($sformatf("v%0d pready low", i), pready_w[vq[i].d], 0);
            chk($sformatf("v%0d wr_stb", i), stb_w[vq[i].d], vq[i].exp_stb);
            if (vq[i].d == 1 && vq[i].addr == 32'h08 && vq[i].wr)
                chk("regs 95:64", regs_w[1][95:64], 32'hDEADBEEF);
        end
        chk("bank3 contents", regs_w[1],
            {RV, RV, RV, RV, RV, 32'hDEADBEEF, 32'hAA22CC44, RV});

        // Abort: psel dropped in 2nd ACCESS cycle of a write to reg 3
        paddr_v[1] = 32'h0C; pwrite_v[1] = 1'b1; pwdata_v[1] = 32'h0BADF00D;
        pstrb_v[1] = 4'hF; psel_v[1] = 1'b1; penable_v[1] = 1'b0;
        @(posedge clk); #1 penable_v[1] = 1'b1;
        @(posedge clk); #1 psel_v[1] = 1'b0; penable_v[1] = 1'b0;
        @(negedge clk);
        chk("abort pready", pready_w[1], 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort stb", stb_w[1], 0);
        xfer(1, 0, 32'h0C, 0, 4'hF, rd, err, waits, ok);
        chk("post-abort done", ok, 1);
        chk("post-abort waits", waits, 3);
        chk("post-abort data", rd, RV);

        // Reset during ACCESS of a write to reg 2
        paddr_v[1] = 32'h08; pwrite_v[1] = 1'b1; pwdata_v[1] = 32'h77778888;
        pstrb_v[1] = 4'hF; psel_v[1] = 1'b1; penable_v[1] = 1'b0;
        @(posedge clk); #1 penable_v[1] = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst pready", pready_w[1], 0);
        chk("midrst stb", stb_w[1], 0);
        chk("midrst reg2", regs_w[1][95:64], RV);
        chk("midrst regs3", regs_w[1], {8{RV}});
        chk("midrst regs0", regs_w[0], 256'h0);
        // psel+penable still high in IDLE: must be ignored
        @(posedge clk); #1;
        @(negedge clk);
        chk("penable in idle", pready_w[1], 0);
        psel_v[1] = 1'b0; penable_v[1] = 1'b0;
        xfer(1, 0, 32'h08, 0, 4'hF, rd, err, waits, ok);
        chk("midrst readback done", ok, 1);
        chk("midrst readback", rd, RV);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/apb_regbank_slave.md
# apb_regbank_slave

Parametrised APB4 completer that terminates the UART subsystem's APB bus in a bank of `NUM_REGS` read/write registers. It adds configurable wait states, byte write strobes and error reporting. It sits between the APB interconnect and the UART core's control/status fabric. Register contents are exposed as a flat vector, with a one-cycle write pulse per register.

## Interface
Parameters:
- `ADDR_W`, 32: width of `paddr`.
- `DATA_W`, 32: data width; 8, 16 or 32 only.
- `NUM_REGS`, 8: number of registers, 1..256.
- `WAIT_STATES`, 0: cycles with `pready`=0 in every ACCESS phase, 0..15.
- `RESET_VAL`, 0: reset value of every register, `DATA_W` bits.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk` in 1: clock.
  - `rst` in 1: synchronous, active-high reset, sampled on posedge `clk`.
- APB completer side:
  - `paddr` in `ADDR_W`: byte address.
  - `psel` in 1: select.
  - `penable` in 1: access phase.
  - `pwrite` in 1: 1=write.
  - `pwdata` in `DATA_W`: write data.
  - `pstrb` in `DATA_W/8`: byte lane strobes.
  - `prdata` out `DATA_W`: read data.
  - `pready` out 1: transfer complete.
  - `pslverr` out 1: transfer error.
- Register side:
  - `regs_o` out `NUM_REGS*DATA_W`: register contents; reg k occupies bits [k*DATA_W +: DATA_W].
  - `wr_stb_o` out `NUM_REGS`: one-cycle pulse on bit k when reg k is written.

## Operation
- Byte offset `OFS = log2(DATA_W/8)`. Register index is `paddr[OFS +: log2(NUM_REGS)]`, with index width at least 1.
- An address is valid when the low `OFS` bits are 0 and `paddr>>OFS < NUM_REGS`.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE→SETUP when `psel`=1 and `penable`=0.
  - SETUP→ACCESS unconditionally.
  - ACCESS→IDLE when `pready`=1, or when `psel` drops.
  - ACCESS→SETUP is not allowed. A back-to-back transfer passes through IDLE-equivalent sampling: if `psel`=1 and `penable`=0 on the cycle after completion, the FSM enters SETUP directly.
- Wait counter:
  - Loaded with `WAIT_STATES` on the SETUP cycle.
  - Decrements each ACCESS cycle while nonzero.
  - `pready` = (state==ACCESS) && (cnt==0).
- Write:
  - Commits at the posedge ending the `pready`=1 cycle, only for a valid address and when `pslverr`=0.
  - Byte lane b updates only if `pstrb[b]`=1.
  - `wr_stb_o[idx]` pulses for exactly the cycle after commit, even if `pstrb`=0.
- Read:
  - `prdata` = reg[idx] during ACCESS with `pready`=1 and `pwrite`=0; otherwise all zeros.
  - `pstrb` is ignored on reads.
- Protocol violations:
  - `penable`=1 while IDLE is ignored: no state change, `pready`=0.
  - `psel` deasserted in ACCESS before `pready` aborts the transfer: no write, no strobe, back to IDLE.
- Reset mid-transfer: FSM goes to IDLE, counter to 0, all registers to `RESET_VAL`, and the pending write is discarded.

## Timing
- Reset values: `prdata`=0, `pready`=0, `pslverr`=0, `wr_stb_o`=0, `regs_o`={NUM_REGS{RESET_VAL}}.
- Transfer length is 2+`WAIT_STATES` cycles (SETUP + ACCESS).
- `regs_o` reflects a write one cycle after the `pready` cycle.
- `pslverr` is valid only when `pready`=1, and is 0 otherwise.
- A read in the cycle immediately after a write to the same register returns the new value.

## Configuration
- Macro: `APB_REGBANK_SLVERR_EN`.
- Defined:
  - An invalid address drives `pslverr`=1 in the `pready` cycle.
  - The write is dropped; read `prdata`=0.
  - A write with `pstrb`=0 also sets `pslverr`=1 and is dropped, with no strobe.
- Undefined:
  - `pslverr` is tied to 0.
  - Invalid writes are silently dropped; invalid reads return 0.
  - `pstrb`=0 writes complete normally, change no bytes, and still pulse `wr_stb_o`.

## Test plan
- Reset with defaults, then read reg 0..7 → `prdata`=0 each, 2-cycle transfers, `pready` high exactly one cycle per transfer.
- `WAIT_STATES`=3: write 0xDEADBEEF to `paddr`=0x8 → `pready`=0 for 3 ACCESS cycles then 1. Next cycle `regs_o[95:64]`=0xDEADBEEF and `wr_stb_o`=8'b0000_0100.
- Write 0x11223344 with `pstrb`=4'b0101 over reg 1 holding 0xAABBCCDD → reg 1 = 0xAA22CC44.
- With `APB_REGBANK_SLVERR_EN`: write to `paddr`=0x20 or 0x6 → `pslverr`=1, `regs_o` unchanged, no strobe. Without the macro → `pslverr`=0, `regs_o` unchanged.
- `psel` dropped in the 2nd ACCESS cycle with `WAIT_STATES`=3 → no write, no strobe. The next SETUP is accepted the following cycle.
- `rst` asserted during ACCESS of a write to reg 2 → all outputs return to reset values next cycle, and reg 2 = `RESET_VAL`.
